// File: rtl/program_counter_stack.sv
// Program counter with a LIFO return-address stack for the fetch stage.
// Supports increment, absolute load, signed relative branch, call/return and stall.
// Ports:
//   Clock          - system clock, rising-edge active
//   nReset         - asynchronous active-low reset
//   Stall          - hold all state, ignore other controls
//   LoadValue      - absolute target for LoadEnable and Call
//   LoadEnable     - absolute jump request
//   Offset         - signed relative branch offset
//   OffsetEnable   - relative branch request
//   Call           - push PC+1, jump to LoadValue
//   Return         - pop top of stack into PC
//   CounterValue   - current program counter (registered)
//   StackCount     - number of valid stack entries (registered)
//   StackOverflow  - sticky, Call while stack full
//   StackUnderflow - sticky, Return while stack empty
module program_counter_stack #(
  parameter int unsigned      WIDTH        = 16,
  parameter int unsigned      OFFSET_WIDTH = 9,
  parameter int unsigned      STACK_DEPTH  = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                             Clock,
  input  logic                             nReset,
  input  logic                             Stall,
  input  logic [WIDTH-1:0]                 LoadValue,
  input  logic                             LoadEnable,
  input  logic [OFFSET_WIDTH-1:0]          Offset,
  input  logic                             OffsetEnable,
  input  logic                             Call,
  input  logic                             Return,
  output logic [WIDTH-1:0]                 CounterValue,
  output logic [$clog2(STACK_DEPTH):0]     StackCount,
  output logic                             StackOverflow,
  output logic                             StackUnderflow
);

  localparam int unsigned AW = $clog2(STACK_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] pc_q, pc_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             ovf_q, ovf_nxt;
  logic             unf_q, unf_nxt;
  logic             push_en;

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] offset_ext;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;
  logic [WIDTH-1:0] stack_top;
  logic             stack_full;
  logic             stack_empty;

  // Datapath helpers; entry i holds the i-th pushed address, count points at next free slot
  always_comb begin
    pc_inc      = pc_q + WIDTH'(1);
    offset_ext  = WIDTH'($signed(Offset));
    push_idx    = AW'(cnt_q);
    pop_idx     = AW'(cnt_q - CW'(1));
    stack_top   = stack_mem[pop_idx];
    stack_full  = (cnt_q == CW'(STACK_DEPTH));
    stack_empty = (cnt_q == '0);
  end

  // Next-state selection, priority Return > Call > Load > Offset > increment
  always_comb begin
    pc_nxt  = pc_q;
    cnt_nxt = cnt_q;
    ovf_nxt = ovf_q;
    unf_nxt = unf_q;
    push_en = 1'b0;
    if (!Stall) begin
      if (Return) begin
        if (!stack_empty) begin
          pc_nxt  = stack_top;
          cnt_nxt = cnt_q - CW'(1);
        end else begin
          pc_nxt  = pc_inc;
          unf_nxt = 1'b1;
        end
      end else if (Call) begin
        pc_nxt = LoadValue;
        if (!stack_full) begin
          push_en = 1'b1;
          cnt_nxt = cnt_q + CW'(1);
        end else begin
          ovf_nxt = 1'b1;
        end
      end else if (LoadEnable) begin
        pc_nxt = LoadValue;
      end else if (OffsetEnable) begin
        pc_nxt = pc_q + offset_ext;
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  // Control/status registers
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pc_q  <= RESET_VALUE;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_nxt;
      cnt_q <= cnt_nxt;
      ovf_q <= ovf_nxt;
      unf_q <= unf_nxt;
    end
  end

  // Stack storage; contents are don't-care after reset so it carries no reset
  always_ff @(posedge Clock) begin
    if (push_en) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign CounterValue   = pc_q;
  assign StackCount     = cnt_q;
  assign StackOverflow  = ovf_q;
  assign StackUnderflow = unf_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Self-checking bench for program_counter_stack: vector table, corner sequences, random vs model.
module tb_program_counter_stack;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned OW    = 9;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic              Clock = 1'b0;
  logic              nReset;
  logic              Stall;
  logic [WIDTH-1:0]  LoadValue;
  logic              LoadEnable;
  logic [OW-1:0]     Offset;
  logic              OffsetEnable;
  logic              Call;
  logic              Return;
  logic [WIDTH-1:0]  CounterValue;
  logic [CW-1:0]     StackCount;
  logic              StackOverflow;
  logic              StackUnderflow;

  always #5 Clock = ~Clock;

  program_counter_stack #(
    .WIDTH(WIDTH), .OFFSET_WIDTH(OW), .STACK_DEPTH(DEPTH), .RESET_VALUE(16'h0000)
  ) dut (
    .Clock(Clock), .nReset(nReset), .Stall(Stall), .LoadValue(LoadValue),
    .LoadEnable(LoadEnable), .Offset(Offset), .OffsetEnable(OffsetEnable),
    .Call(Call), .Return(Return), .CounterValue(CounterValue),
    .StackCount(StackCount), .StackOverflow(StackOverflow), .StackUnderflow(StackUnderflow)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model
  int          m_pc;
  int          m_stack[$];
  bit          m_ovf, m_unf;

  typedef struct {
    string       name;
    bit          st, rt, cl, ld, oe;
    logic [15:0] lv;
    logic [8:0]  off;
    logic [15:0] epc;
    logic [3:0]  ecnt;
    bit          eovf, eunf;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int pc, input int cnt, input bit ovf, input bit unf);
    chk({tag, ".pc"},  32'(CounterValue),   32'(pc));
    chk({tag, ".cnt"}, 32'(StackCount),     32'(cnt));
    chk({tag, ".ovf"}, 32'(StackOverflow),  32'(ovf));
    chk({tag, ".unf"}, 32'(StackUnderflow), 32'(unf));
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, m_pc, m_stack.size(), m_ovf, m_unf);
  endtask

  task automatic drive(input bit st, input bit rt, input bit cl, input bit ld, input bit oe,
                       input logic [15:0] lv, input logic [8:0] off);
    Stall = st; Return = rt; Call = cl; LoadEnable = ld; OffsetEnable = oe;
    LoadValue = lv; Offset = off;
  endtask

  task automatic model_reset();
    m_pc = 0; m_stack.delete(); m_ovf = 0; m_unf = 0;
  endtask

  // Applies the specification's priority rules with plain integer arithmetic
  task automatic model_step();
    int soff;
    if (Stall) return;
    if (Return) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin m_pc = (m_pc + 1) % 65536; m_unf = 1; end
    end else if (Call) begin
      if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % 65536);
      else m_ovf = 1;
      m_pc = int'(LoadValue);
    end else if (LoadEnable) begin
      m_pc = int'(LoadValue);
    end else if (OffsetEnable) begin
      soff = int'(Offset);
      if (soff >= 256) soff -= 512;
      m_pc = (m_pc + soff + 65536) % 65536;
    end else begin
      m_pc = (m_pc + 1) % 65536;
    end
  endtask

  // One clock: inputs already driven, sample #1 after the edge
  task automatic clk_step();
    @(posedge Clock);
    #1;
    model_step();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 16'h0, 9'h0);
    nReset = 1'b0;
    @(posedge Clock);
    #1;
    nReset = 1'b1;
    model_reset();
  endtask

  task automatic add(input string n, input bit st, input bit rt, input bit cl, input bit ld,
                     input bit oe, input logic [15:0] lv, input logic [8:0] off,
                     input logic [15:0] epc, input logic [3:0] ecnt, input bit eovf, input bit eunf);
    vec_t v;
    v.name = n; v.st = st; v.rt = rt; v.cl = cl; v.ld = ld; v.oe = oe;
    v.lv = lv; v.off = off; v.epc = epc; v.ecnt = ecnt; v.eovf = eovf; v.eunf = eunf;
    vecs.push_back(v);
  endtask

  int unsigned tgt[9];

  initial begin
    //      name        st rt cl ld oe  lv        off     pc        cnt ovf unf
    add("load_f0f0",    0, 0, 0, 1, 0, 16'hF0F0, 9'h000, 16'hF0F0, 0, 0, 0);
    add("inc_f0f1",     0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'hF0F1, 0, 0, 0);
    add("stall1",       1, 0, 0, 0, 0, 16'h0000, 9'h000, 16'hF0F1, 0, 0, 0);
    add("stall2",       1, 0, 0, 0, 0, 16'h0000, 9'h000, 16'hF0F1, 0, 0, 0);
    add("stall_ctrl",   1, 1, 1, 1, 1, 16'h1234, 9'h005, 16'hF0F1, 0, 0, 0);
    add("release",      0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'hF0F2, 0, 0, 0);
    add("load_0010",    0, 0, 0, 1, 0, 16'h0010, 9'h000, 16'h0010, 0, 0, 0);
    add("off_p37",      0, 0, 0, 0, 1, 16'h0000, 9'h037, 16'h0047, 0, 0, 0);
    add("off_m2",       0, 0, 0, 0, 1, 16'h0000, 9'h1FE, 16'h0045, 0, 0, 0);
    add("load_ffff",    0, 0, 0, 1, 0, 16'hFFFF, 9'h000, 16'hFFFF, 0, 0, 0);
    add("wrap_inc",     0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0000, 0, 0, 0);
    add("wrap_off_m1",  0, 0, 0, 0, 1, 16'h0000, 9'h1FF, 16'hFFFF, 0, 0, 0);
    add("load_0100",    0, 0, 0, 1, 0, 16'h0100, 9'h000, 16'h0100, 0, 0, 0);
    add("call_0200",    0, 0, 1, 0, 0, 16'h0200, 9'h000, 16'h0200, 1, 0, 0);
    add("inc_a",        0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0201, 1, 0, 0);
    add("inc_b",        0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0202, 1, 0, 0);
    add("inc_c",        0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0203, 1, 0, 0);
    add("ret_0101",     0, 1, 0, 0, 0, 16'h0000, 9'h000, 16'h0101, 0, 0, 0);
    add("call_0300",    0, 0, 1, 0, 0, 16'h0300, 9'h000, 16'h0300, 1, 0, 0);
    add("all_ctrl",     0, 1, 1, 1, 1, 16'h0500, 9'h005, 16'h0102, 0, 0, 0);
    add("call_ld",      0, 0, 1, 1, 0, 16'h0400, 9'h000, 16'h0400, 1, 0, 0);
    add("ret_0103",     0, 1, 0, 0, 0, 16'h0000, 9'h000, 16'h0103, 0, 0, 0);
    add("ret_empty",    0, 1, 0, 0, 0, 16'h0000, 9'h000, 16'h0104, 0, 0, 1);
    add("unf_sticky",   0, 0, 0, 0, 0, 16'h0000, 9'h000, 16'h0105, 0, 0, 1);
    add("ld_oe",        0, 0, 0, 1, 1, 16'h0777, 9'h0FF, 16'h0777, 0, 0, 1);

    // Reset state and free-running count
    drive(0, 0, 0, 0, 0, 16'h0, 9'h0);
    nReset = 1'b0;
    #2;
    chk_all("reset_async0", 0, 0, 0, 0);
    @(posedge Clock); #1;
    nReset = 1'b1;
    model_reset();
    chk_all("reset", 0, 0, 0, 0);
    repeat (20) clk_step();
    chk_all("free20", 20, 0, 0, 0);
    nReset = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0);
    @(posedge Clock); #1;
    nReset = 1'b1;
    model_reset();

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].rt, vecs[i].cl, vecs[i].ld, vecs[i].oe, vecs[i].lv, vecs[i].off);
      clk_step();
      chk_all(vecs[i].name, vecs[i].epc, vecs[i].ecnt, vecs[i].eovf, vecs[i].eunf);
    end

    // Nested calls to overflow, LIFO unwind, then underflow
    do_reset();
    drive(0, 0, 0, 1, 0, 16'h0800, 9'h0);
    clk_step();
    for (int i = 0; i < 9; i++) tgt[i] = 32'h1000 + 32'(i) * 32'h10;
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 1, 0, 0, 16'(tgt[i]), 9'h0);
      clk_step();
      chk_all($sformatf("call%0d", i), int'(tgt[i]), (i < 8) ? i + 1 : 8, (i == 8), 0);
    end
    for (int r = 0; r < 8; r++) begin
      drive(0, 1, 0, 0, 0, 16'h0, 9'h0);
      clk_step();
      chk_all($sformatf("unwind%0d", r), (r < 7) ? int'(tgt[6 - r]) + 1 : 16'h0801, 7 - r, 1, 0);
    end
    drive(0, 1, 0, 0, 0, 16'h0, 9'h0);
    clk_step();
    chk_all("ret9", 16'h0802, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 16'h0, 9'h0);
    repeat (3) clk_step();
    chk_all("sticky", 16'h0805, 0, 1, 1);
    do_reset();
    chk_all("flags_clear", 0, 0, 0, 0);

    // Randomised run against the model
    for (int n = 0; n < 3000; n++) begin
      if (n % 600 == 599) begin
        do_reset();
        chk_model("rand_reset");
      end
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
            16'($urandom), 9'($urandom));
      clk_step();
      chk_model($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
